// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared constants, FSM state encoding and the bit-serial
// CRC-16/MODBUS step for the 7-byte Modbus-RTU frame transmitter.
package tx_frame_pkg;

  localparam int unsigned FRAME_BYTES = 7;
  localparam int unsigned DATA_BITS   = 8;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'hA001;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_e;

  // One reflected CRC-16 step for a single transmitted data bit.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    crc_step = (crc >> 1) ^ (((crc[0] ^ bit_in) == 1'b1) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tx_frame_module_bps.sv
// tx_bps_module: baud counter for the frame transmitter.
// Ports:
//   CLK, RSTn  - clock, asynchronous active-low reset
//   clear      - holds the counter at 0
//   enable     - counts 0..BPS_DIV-1 and wraps
//   bit_end    - one-cycle tick in the cycle the count is BPS_DIV-1
module tx_bps_module #(
  parameter int unsigned BPS_DIV = 5208
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CNT_W = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_frame_module.sv
// tx_frame_module: Modbus-RTU 7-byte frame transmitter (seven contiguous
// 8N1 characters, byte 0 first, LSB first) with its own baud generator.
// Ports:
//   CLK, RSTn    - clock, asynchronous active-low reset
//   TX_En_Sig    - start request, honoured only in IDLE or DONE
//   TX_Data      - 56-bit frame, byte k = TX_Data[8k+7:8k]
//   TX_Pin_Out   - serial line (idles high)
//   TX_Busy_Sig  - high while a frame is in flight
//   TX_Done_Sig  - one-cycle pulse after the last stop bit
// Build option: MODBUS_TX_CRC_EN replaces bytes 5/6 with the CRC-16/MODBUS
// of bytes 0-4 (low byte first).
module tx_frame_module
  import tx_frame_pkg::*;
#(
  parameter int unsigned BPS_DIV = 5208
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        TX_En_Sig,
  input  logic [55:0] TX_Data,
  output logic        TX_Pin_Out,
  output logic        TX_Busy_Sig,
  output logic        TX_Done_Sig
);

  tx_state_e   state_q, state_d;
  logic [55:0] shreg_q, shreg_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        pin_q, pin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        bps_clear;
`ifdef MODBUS_TX_CRC_EN
  logic [15:0] crc_q, crc_d;
`endif

  assign bps_clear = (state_q == IDLE) || (state_q == DONE);

  tx_bps_module #(.BPS_DIV(BPS_DIV)) u_bps (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clear   (bps_clear),
    .enable  (!bps_clear),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
`ifdef MODBUS_TX_CRC_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (TX_En_Sig) begin
          state_d    = START;
          shreg_d    = TX_Data;
          byte_idx_d = '0;
          bit_idx_d  = '0;
`ifdef MODBUS_TX_CRC_EN
          crc_d      = CRC_INIT;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
`ifdef MODBUS_TX_CRC_EN
          if (byte_idx_q < 3'd5) crc_d = crc_step(crc_q, shreg_q[0]);
`endif
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
`ifdef MODBUS_TX_CRC_EN
        // After five bytes have shifted out, bytes 5/6 sit in [15:0].
        if (byte_idx_q == 3'd4) shreg_d[15:0] = crc_q;
`endif
        if (bit_end) begin
          if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    pin_d  = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      START: begin pin_d = 1'b0;       busy_d = 1'b1; end
      DATA:  begin pin_d = shreg_d[0]; busy_d = 1'b1; end
      STOP:  begin                     busy_d = 1'b1; end
      DONE:  begin done_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      pin_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MODBUS_TX_CRC_EN
      crc_q      <= CRC_INIT;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      pin_q      <= pin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MODBUS_TX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign TX_Pin_Out  = pin_q;
  assign TX_Busy_Sig = busy_q;
  assign TX_Done_Sig = done_q;

endmodule

// File: doc/tx_frame_module.md
# tx_frame_module

Modbus-RTU frame transmitter for the PS/2-to-UART bridge. Sends a 7-byte (56-bit) frame as seven contiguous 8N1 UART characters on one pin. It is the transmit counterpart of the 7-byte frame receiver. It carries its own baud-tick generator, so the caller only supplies a start pulse and the frame word.

## Interface
- BPS_DIV, 5208: CLK cycles per bit time (50 MHz / 9600 baud); legal range is ≥ 2.
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- TX_En_Sig  in  1  start request; sampled only in IDLE or DONE.
- TX_Data  in  56  frame; byte k = TX_Data[8k+7:8k]; byte 0 (address) is sent first.
- TX_Pin_Out  out  1  serial line; idles high.
- TX_Busy_Sig  out  1  high while a frame is in flight.
- TX_Done_Sig  out  1  one-cycle pulse when the frame has completed.

## Operation
- FSM states: IDLE, START, DATA, STOP, DONE. Counters: byte index 0..6, bit index 0..7, baud counter 0..BPS_DIV-1.
- **IDLE / DONE → START:** triggered by TX_En_Sig=1.
  - TX_Data is latched into a 56-bit shift register.
  - Byte index, bit index and baud counter clear to 0.
  - Data changes after acceptance have no effect on the frame.
- **START:** drives the line 0 for one bit time, then goes to DATA.
- **DATA:** drives the current LSB of the current byte. After each bit time the register shifts right by 1. After bit 7 the FSM goes to STOP.
- **STOP:** drives the line 1 for one bit time.
  - If byte index < 6: increment it and go to START. There is no inter-character gap.
  - If byte index = 6: go to DONE.
- **DONE:** lasts one cycle. TX_Done_Sig=1 and TX_Busy_Sig=0. Without a new TX_En_Sig the FSM returns to IDLE.
- TX_En_Sig in START/DATA/STOP is ignored; it is not queued.
- Reset values: TX_Pin_Out=1, TX_Busy_Sig=0, TX_Done_Sig=0, FSM=IDLE, all counters 0. Reset mid-frame returns the line high immediately and aborts the frame with no done pulse.

## Timing
- All outputs are registered.
- TX_Pin_Out falls in the cycle after TX_En_Sig is sampled high. TX_Busy_Sig rises in that same cycle.
- Every bit is held exactly BPS_DIV cycles. A frame is 70 bit times = 70·BPS_DIV cycles, from the falling start edge to the end of the last stop bit.
- TX_Done_Sig pulses in the cycle immediately after the last stop-bit cycle.
- Back-to-back frames: TX_En_Sig asserted in the DONE cycle starts the next frame in the following cycle. The idle gap is therefore 1 cycle.
- Baud counter: a bit time ends when the counter reaches BPS_DIV-1; the counter then wraps to 0. Its width is $clog2(BPS_DIV).

## Configuration
- Macro: MODBUS_TX_CRC_EN.
- **Defined:** bytes 5 and 6 carry the CRC-16/MODBUS of bytes 0–4. Byte 5 is the CRC low byte and byte 6 the CRC high byte. TX_Data[55:40] is ignored.
  - The CRC is computed bit-serially as data bits of bytes 0–4 are sent: crc = (crc>>1) ^ ((crc[0]^bit) ? 16'hA001 : 0).
  - The CRC initialises to 16'hFFFF on frame accept.
  - The CRC is loaded into shift-register bytes 5–6 during byte 4's STOP bit, before byte 5's START bit.
- **Undefined:** all 56 bits of TX_Data are sent verbatim and no CRC logic is present.

## Structure
- Package tx_frame_pkg holds:
  - FRAME_BYTES=7, DATA_BITS=8
  - CRC_INIT=16'hFFFF, CRC_POLY=16'hA001
  - the FSM state encoding
- Sub-module tx_bps_module: the baud counter.
  - Inputs: clear and enable.
  - Output: a one-cycle bit-end tick at count BPS_DIV-1.

## Test plan
- **Basic frame:** BPS_DIV=4, TX_Data=56'h07_06_05_04_03_02_01, one-cycle TX_En_Sig (CRC macro undefined) →
  - bytes 01..07 appear in order, each with start 0, LSB first, stop 1;
  - every bit lasts 4 cycles;
  - TX_Done_Sig pulses exactly 280 cycles after the line first falls.
- **Ignored and back-to-back starts:** pulse TX_En_Sig mid-frame → no effect. Then hold TX_En_Sig high through DONE → second frame starts 1 cycle after the done pulse.
- **Data latching:** change TX_Data every cycle after acceptance → the transmitted bytes equal the value latched at acceptance.
- **Mid-frame reset:** RSTn low during byte 3 → TX_Pin_Out=1 and TX_Busy_Sig=0 immediately; no done pulse; the next start sends a clean frame.
- **CRC (MODBUS_TX_CRC_EN defined):** TX_Data low bytes 01 03 00 00 01 →
  - bytes 5/6 equal the bench CRC-16/MODBUS model (low byte first);
  - any TX_Data[55:40] value has no effect.
- **Minimum divider:** BPS_DIV=2 → each bit lasts 2 cycles and the frame is 140 cycles, with no dropped or extra bits.
